// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two cores, with
// LR/SC reservation tracking. A failing SC is answered locally without a RAM access.
module dual_core_mem_arbiter #(
  parameter int NCORES = 2,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NCORES-1:0]          dREN,
  input  logic [NCORES-1:0]          dWEN,
  input  logic [NCORES-1:0]          datomic,
  input  logic [NCORES*WORD_W-1:0]   daddr,
  input  logic [NCORES*WORD_W-1:0]   dstore,
  output logic [NCORES-1:0]          dwait,
  output logic [NCORES*WORD_W-1:0]   dload,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [WORD_W-1:0]          ramaddr,
  output logic [WORD_W-1:0]          ramstore,
  input  logic [WORD_W-1:0]          ramload,
  input  logic                       ram_busy,
  output logic [1:0]                 o_dbg_state
);

  // Handshake: core i holds dREN/dWEN/daddr/dstore stable while it requests;
  // the request completes in the cycle where dwait[i]=0 with dREN[i]|dWEN[i] high.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_SC_FAIL = 2'd2
  } state_t;

  state_t                    r_state;
  logic                      r_grant;
  logic                      r_last;
  logic [NCORES-1:0]         r_resv_valid;
  logic [NCORES-1:0][WORD_W-3:0] r_resv_addr;

  logic [NCORES-1:0][WORD_W-1:0] w_addr;
  logic [NCORES-1:0][WORD_W-1:0] w_store;
  logic [NCORES-1:0][WORD_W-1:0] w_dload;
  logic [NCORES-1:0]         w_req;
  logic [NCORES-1:0]         w_lr;
  logic [NCORES-1:0]         w_sc;
  logic                      w_pick;
  logic                      w_sc_hit;
  logic                      w_g_rd;
  logic [WORD_W-3:0]         w_g_word;

  assign w_addr   = daddr;
  assign w_store  = dstore;
  assign w_req    = dREN | dWEN;
  // A request with both enables set is a write, so it can never be an LR.
  assign w_lr     = dREN & ~dWEN & datomic;
  assign w_sc     = dWEN & datomic;
  assign w_pick   = (w_req == 2'b11) ? ~r_last : w_req[1];
  assign w_sc_hit = r_resv_valid[w_pick] &&
                    (r_resv_addr[w_pick] == w_addr[w_pick][WORD_W-1:2]);
  assign w_g_rd   = dREN[r_grant] & ~dWEN[r_grant];
  assign w_g_word = w_addr[r_grant][WORD_W-1:2];
  assign dload    = w_dload;
  assign o_dbg_state = r_state;

  always_comb begin
    dwait    = w_req;
    w_dload  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      S_ACCESS: begin
        ramREN   = w_g_rd;
        ramWEN   = dWEN[r_grant];
        ramaddr  = w_addr[r_grant];
        ramstore = w_store[r_grant];
        dwait[r_grant] = w_req[r_grant] & ram_busy;
        if (!ram_busy && w_g_rd)
          w_dload[r_grant] = ramload;
      end
      S_SC_FAIL: begin
        dwait[r_grant]   = 1'b0;
        w_dload[r_grant] = {{(WORD_W-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last       <= 1'b1;
      r_resv_valid <= '0;
      r_resv_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_state <= (w_sc[w_pick] && !w_sc_hit) ? S_SC_FAIL : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!ram_busy) begin
            r_last  <= r_grant;
            r_state <= S_IDLE;
            if (w_lr[r_grant]) begin
              r_resv_valid[r_grant] <= 1'b1;
              r_resv_addr[r_grant]  <= w_g_word;
            end
            // Any completed write kills every reservation on that word, the writer's included.
            if (dWEN[r_grant]) begin
              for (int j = 0; j < NCORES; j++)
                if (r_resv_addr[j] == w_g_word)
                  r_resv_valid[j] <= 1'b0;
              if (w_sc[r_grant])
                r_resv_valid[r_grant] <= 1'b0;
            end
          end
        end
        S_SC_FAIL: begin
          r_resv_valid[r_grant] <= 1'b0;
          r_last                <= r_grant;
          r_state               <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
- Shares the single data-memory port between the two cores' datapaths. Round-robin arbitration.
- Implements LR/SC semantics for requests flagged by the control unit's datomic signal.
- Keeps one word reservation per core and invalidates it on conflicting writes. SC failures return without touching memory.
- Sits between the two core data-side request buses and the RAM controller.

Parameters:
- NCORES, 2, number of requesters (only 2 supported)
- WORD_W, 32, data/address width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- dREN  in  2  per-core read request (bit i = core i)
- dWEN  in  2  per-core write request
- datomic  in  2  per-core atomic flag (LR when with dREN, SC when with dWEN)
- daddr  in  2x32  per-core byte address
- dstore  in  2x32  per-core write data
- dwait  out  2  per-core stall; low = request completes this cycle
- dload  out  2x32  per-core read data / SC result, valid when dwait[i]=0 and core i requesting
- ramREN  out  1  memory read enable
- ramWEN  out  1  memory write enable
- ramaddr  out  32  memory address
- ramstore  out  32  memory write data
- ramload  in  32  memory read data
- ram_busy  in  1  memory not ready; access completes on first cycle with ram_busy=0

Behaviour:
- State registers and reset values:
  - States: IDLE, ACCESS, SC_FAIL.
  - Registers: state, grant (1 bit), last (1 bit), resv_valid[2], resv_addr[2] (addr[31:2]).
  - On RST (any state, including mid-access): state=IDLE, last=1, resv_valid=0, resv_addr=0, grant=0.
- Outputs from IDLE:
  - ramREN=ramWEN=0, ramaddr=ramstore=0, dload=0.
  - dwait[i]=(dREN[i]|dWEN[i]).
  - dwait[i]=0 when core i is not requesting, in every state.
- Request classification:
  - Core i requests when dREN[i]|dWEN[i]. If both are set, it is treated as a write.
  - LR = dREN&datomic. SC = dWEN&datomic.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant = ~last.
  - Granted request is SC and (!resv_valid[g] or resv_addr[g]!=daddr[g][31:2]): next state SC_FAIL.
  - Otherwise: next state ACCESS. No request: stay in IDLE.
- ACCESS:
  - ramREN/ramWEN/ramaddr/ramstore follow the granted core's dREN/dWEN/daddr/dstore combinationally.
  - Non-granted core: dwait=1 if requesting.
  - While ram_busy=1: dwait[g]=1.
  - First cycle with ram_busy=0: dwait[g]=0. dload[g]=ramload for reads, 0 for SC success, 0 for plain writes. Then last<=g and next state IDLE.
- SC_FAIL (one cycle):
  - ram outputs are 0.
  - dwait[g]=0, dload[g]=32'h1, resv_valid[g]<=0, last<=g. Next state IDLE.
- Reservation updates (on the completion cycle only):
  - LR by core i: resv_valid[i]<=1, resv_addr[i]<=daddr[i][31:2]. Replaces any prior reservation.
  - Successful SC by core i: resv_valid[i]<=0.
  - Any completed write (plain or SC) by core g to word A: clear resv_valid[j] for every j with resv_addr[j]==A, including j=g.
  - LR reserving and another core's write in the same cycle cannot occur (single port).
- Latency:
  - Minimum request-to-completion is 2 cycles (IDLE + ACCESS with ram_busy=0); each busy cycle adds 1.
  - SC fail is always 2 cycles.
  - After a completion, IDLE is re-entered. A core re-requesting back-to-back loses to the other core if both request.
- Requesters hold dREN/dWEN/daddr/dstore stable until dwait[i]=0. Deasserting the request early is a protocol violation; the bench flags it as an assertion error.
- Fairness: continuous requests from both cores alternate grants 0,1,0,1...

Test Plan:
- Reset, then core0 reads 0x100 with ram_busy=0 and ramload=0xDEADBEEF -> dwait[0] low in cycle 2, dload[0]=0xDEADBEEF; ramREN=1, ramaddr=0x100 in cycle 2 only.
- Both cores write continuously (addresses 0x200/0x300), ram_busy=1 for 2 cycles per access -> grants alternate 0,1,0,1. Each completion takes 4 cycles; ramWEN address alternates.
- Core0 LR 0x400, then SC 0x400 data 0x5 -> SC takes ACCESS path, ramWEN=1, ramstore=0x5, dload[0]=0; a second SC to 0x400 -> SC_FAIL, dload[0]=1, ramWEN never asserted.
- Core0 LR 0x400, core1 plain write 0x400, core0 SC 0x400 -> core0 SC fails with dload[0]=1; memory unchanged by SC.
- Core0 LR 0x400, core1 write 0x404 (different word), core0 SC 0x400 -> SC succeeds, dload[0]=0; SC 0x408 with resv on 0x400 -> fails.
- Assert RST during ACCESS with ram_busy=1 -> next cycle state IDLE, ramREN=ramWEN=0, reservations cleared; a subsequent SC by either core fails.
